// File: rtl/serial_link_arb_pkg.sv
// Shared types and helpers for the serial-link OBI arbiter.
package serial_link_arb_pkg;

  // Index width that stays at least one bit wide, even for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/serial_link_obi_arbiter_id_fifo.sv
// In-order FIFO of requester indices; non fall-through, head visible while not empty.
module serial_link_obi_arbiter_id_fifo
  import serial_link_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   usage
);

  localparam int unsigned PtrW = idx_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       wr_ptr, rd_ptr;
  logic [CntW-1:0]       cnt;
  logic                  do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CntW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign usage   = cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PtrW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset: it is only read while not empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/serial_link_obi_arbiter.sv
// Round-robin OBI arbiter in front of the serial-link bridge; holds its choice until
// grant and steers each response back to its issuer through an in-order ID FIFO.
module serial_link_obi_arbiter
  import serial_link_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumReq-1:0]                      req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]       addr_i,
  input  logic [NumReq-1:0]                      we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]     be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]       wdata_i,
  output logic [NumReq-1:0]                      gnt_o,
  output logic [NumReq-1:0]                      rvalid_o,
  output logic [NumReq-1:0][DataWidth-1:0]       rdata_o,
  output logic                                   req_o,
  output logic [AddrWidth-1:0]                   addr_o,
  output logic                                   we_o,
  output logic [DataWidth/8-1:0]                 be_o,
  output logic [DataWidth-1:0]                   wdata_o,
  input  logic                                   gnt_i,
  input  logic                                   rvalid_i,
  input  logic [DataWidth-1:0]                   rdata_i,
  output logic                                   spurious_rsp_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o
);

  localparam int unsigned IdxW = idx_width(NumReq);

  lock_state_e     state, state_next;
  logic [IdxW-1:0] rr_ptr, lock_idx, winner, head_idx;
  logic            any_req, fifo_full, fifo_empty, hs, rsp_ok;
  int unsigned     j;

  // Scan from highest index offset down so the slot nearest rr_ptr is written last and wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    j       = 0;
    if (state == LOCKED) begin
      winner  = lock_idx;
      any_req = 1'b1;
    end else begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        j = int'(rr_ptr) + i;
        if (j >= NumReq) j = j - NumReq;
        if (req_i[j]) begin
          winner  = IdxW'(j);
          any_req = 1'b1;
        end
      end
    end
  end

  // Full masks on the registered count only, keeping rvalid_i out of the req_o path.
  assign req_o          = any_req & ~fifo_full;
  assign hs             = req_o & gnt_i;
  assign rsp_ok         = rvalid_i & ~fifo_empty;
  assign spurious_rsp_o = rvalid_i & fifo_empty;
  assign rdata_o        = {NumReq{rdata_i}};

  always_comb begin
    addr_o   = '0;
    we_o     = 1'b0;
    be_o     = '0;
    wdata_o  = '0;
    gnt_o    = '0;
    rvalid_o = '0;
    if (req_o) begin
      addr_o  = addr_i[winner];
      we_o    = we_i[winner];
      be_o    = be_i[winner];
      wdata_o = wdata_i[winner];
    end
    gnt_o[winner]      = hs;
    rvalid_o[head_idx] = rsp_ok;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_o && !gnt_i) state_next = LOCKED;
      LOCKED:  if (gnt_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      lock_idx <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_o && !gnt_i) lock_idx <= winner;
      if (hs) rr_ptr <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
    end
  end

  serial_link_obi_arbiter_id_fifo #(
    .DEPTH      (MaxOutstanding),
    .DATA_WIDTH (IdxW)
  ) i_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (hs),
    .pop    (rsp_ok),
    .wdata  (winner),
    .rdata  (head_idx),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .usage  (outstanding_o)
  );

`ifndef SYNTHESIS
  lock_hold_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state == LOCKED) |-> req_i[lock_idx]);
  no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    hs |-> (!fifo_full || rsp_ok));
`endif

endmodule

// File: tb/tb_serial_link_obi_arbiter.sv
// Directed and randomized checks of the serial-link OBI arbiter against a queue-based model.
module tb_serial_link_obi_arbiter;

  localparam int N  = 2;
  localparam int MO = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = $clog2(MO + 1);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [N-1:0]              req_i;
  logic [N-1:0][AW-1:0]      addr_i;
  logic [N-1:0]              we_i;
  logic [N-1:0][DW/8-1:0]    be_i;
  logic [N-1:0][DW-1:0]      wdata_i;
  logic [N-1:0]              gnt_o, rvalid_o;
  logic [N-1:0][DW-1:0]      rdata_o;
  logic                      req_o, we_o, gnt_i, rvalid_i, spurious;
  logic [AW-1:0]             addr_o;
  logic [DW/8-1:0]           be_o;
  logic [DW-1:0]             wdata_o, rdata_i;
  logic [CW-1:0]             outstanding;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_link_obi_arbiter #(
    .NumReq(N), .MaxOutstanding(MO), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .be_o(be_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .spurious_rsp_o(spurious), .outstanding_o(outstanding)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = '0; addr_i = '0; we_i = '0; be_i = '0; wdata_i = '0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    tests++;
    if ({req_o, gnt_o, rvalid_o, spurious, we_o} !== '0 || addr_o !== '0 || outstanding !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req=%b gnt=%b rvalid=%b spur=%b addr=%h outst=%0d, required all 0",
               req_o, gnt_o, rvalid_o, spurious, addr_o, outstanding);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    req_i = 2'b01; addr_i[0] = 32'h1000_0000; gnt_i = 1'b1;
    @(negedge clk);
    tests++;
    if (gnt_o !== 2'b01 || addr_o !== 32'h1000_0000 || outstanding !== 0) begin
      fails++;
      $display("FAIL single_grant: gnt=%b addr=%h outst=%0d, required 01 10000000 0", gnt_o, addr_o, outstanding);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++;
    if (outstanding !== 1) begin
      fails++;
      $display("FAIL single_outst1: got %0d, required 1", outstanding);
    end
    tick(); tick();
    rvalid_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++;
    if (rvalid_o !== 2'b01 || rdata_o[0] !== 32'hDEAD_BEEF || spurious !== 1'b0) begin
      fails++;
      $display("FAIL single_rsp: rvalid=%b rdata0=%h spur=%b, required 01 deadbeef 0", rvalid_o, rdata_o[0], spurious);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++;
    if (outstanding !== 0) begin
      fails++;
      $display("FAIL single_outst0: got %0d, required 0", outstanding);
    end
    tick();
  endtask

  task automatic test_alternate();
    logic [N-1:0] eg, er;
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      req_i    = (k < 4) ? 2'b11 : 2'b00;
      gnt_i    = (k < 4);
      rvalid_i = (k >= 1);
      rdata_i  = 32'hA000_0000 + k;
      eg = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      er = (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      tests++;
      if (gnt_o !== eg || rvalid_o !== er) begin
        fails++;
        $display("FAIL alternate_c%0d: gnt=%b rvalid=%b, required gnt=%b rvalid=%b", k, gnt_o, rvalid_o, eg, er);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    addr_i[0] = 32'hAAAA_0000; addr_i[1] = 32'hBBBB_0000;
    req_i = 2'b01; gnt_i = 1'b1;
    tick();
    // Pointer now favours requester 1; requester 0 asks again and is stalled.
    for (int k = 1; k <= 5; k++) begin
      req_i    = (k == 1) ? 2'b01 : 2'b11;
      gnt_i    = (k == 5);
      rvalid_i = (k == 1);
      @(negedge clk);
      tests++;
      if (addr_o !== 32'hAAAA_0000 || gnt_o !== ((k == 5) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL lock_hold_c%0d: addr=%h gnt=%b, required aaaa0000 gnt=%b", k, addr_o, gnt_o,
                 (k == 5) ? 2'b01 : 2'b00);
      end
      tick();
    end
    rvalid_i = 1'b0; req_i = 2'b10; gnt_i = 1'b1;
    @(negedge clk);
    tests++;
    if (gnt_o !== 2'b10 || addr_o !== 32'hBBBB_0000) begin
      fails++;
      $display("FAIL lock_next: gnt=%b addr=%h, required 10 bbbb0000", gnt_o, addr_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    req_i = 2'b01; gnt_i = 1'b1; tick();
    req_i = 2'b10; tick();
    req_i = 2'b01;
    @(negedge clk);
    tests++;
    if (req_o !== 1'b0 || gnt_o !== 2'b00 || outstanding !== 2) begin
      fails++;
      $display("FAIL limit_mask: req=%b gnt=%b outst=%0d, required 0 00 2", req_o, gnt_o, outstanding);
    end
    tick();
    rvalid_i = 1'b1;
    @(negedge clk);
    tests++;
    if (req_o !== 1'b0 || rvalid_o !== 2'b01) begin
      fails++;
      $display("FAIL limit_same_cycle_pop: req=%b rvalid=%b, required 0 01", req_o, rvalid_o);
    end
    tick();
    @(negedge clk);
    tests++;
    if (req_o !== 1'b1 || gnt_o !== 2'b01 || rvalid_o !== 2'b10 || outstanding !== 1) begin
      fails++;
      $display("FAIL limit_reassert: req=%b gnt=%b rvalid=%b outst=%0d, required 1 01 10 1",
               req_o, gnt_o, rvalid_o, outstanding);
    end
    tick();
    req_i = '0; gnt_i = 1'b0;
    @(negedge clk);
    tests++;
    if (rvalid_o !== 2'b01) begin
      fails++;
      $display("FAIL limit_order: rvalid=%b, required 01", rvalid_o);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    tests++;
    if (outstanding !== 0) begin
      fails++;
      $display("FAIL limit_drain: outst=%0d, required 0", outstanding);
    end
    tick();
  endtask

  task automatic test_spurious();
    do_reset();
    rvalid_i = 1'b1; rdata_i = 32'h1234_5678;
    @(negedge clk);
    tests++;
    if (spurious !== 1'b1 || rvalid_o !== 2'b00 || outstanding !== 0) begin
      fails++;
      $display("FAIL spurious_pulse: spur=%b rvalid=%b outst=%0d, required 1 00 0", spurious, rvalid_o, outstanding);
    end
    tick();
    rvalid_i = 1'b0;
    @(negedge clk);
    tests++;
    if (spurious !== 1'b0 || outstanding !== 0) begin
      fails++;
      $display("FAIL spurious_clear: spur=%b outst=%0d, required 0 0", spurious, outstanding);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_i = 2'b01; gnt_i = 1'b1; tick();
    req_i = 2'b10; tick();
    idle_inputs();
    @(negedge clk);
    tests++;
    if (outstanding !== 2) begin
      fails++;
      $display("FAIL rstmid_pre: outst=%0d, required 2", outstanding);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (outstanding !== 0) begin
      fails++;
      $display("FAIL rstmid_async: outst=%0d, required 0", outstanding);
    end
    tick();
    rst_n = 1'b1;
    tick();
    rvalid_i = 1'b1;
    @(negedge clk);
    tests++;
    if (spurious !== 1'b1 || rvalid_o !== 2'b00 || outstanding !== 0) begin
      fails++;
      $display("FAIL rstmid_rsp: spur=%b rvalid=%b outst=%0d, required 1 00 0", spurious, rvalid_o, outstanding);
    end
    tick();
    idle_inputs();
  endtask

  // Each requester holds its request until granted; the model tracks issue order
  // as a queue, the next-preferred requester, and any requester stuck awaiting grant.
  task automatic test_random();
    int          q[$];
    int          rr, lock, w;
    logic        any, ereq;
    logic [N-1:0] eg, er;
    do_reset();
    rr = 0; lock = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_i[i] && $urandom_range(0, 2) == 0) begin
          req_i[i]   = 1'b1;
          addr_i[i]  = $urandom;
          we_i[i]    = $urandom_range(0, 1);
          be_i[i]    = $urandom;
          wdata_i[i] = $urandom;
        end
      end
      gnt_i    = $urandom_range(0, 1);
      rvalid_i = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      rdata_i  = $urandom;
      any = 1'b0; w = 0;
      if (lock >= 0) begin
        any = 1'b1; w = lock;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (req_i[(rr + k) % N]) begin
            any = 1'b1; w = (rr + k) % N;
            break;
          end
        end
      end
      ereq = any && (q.size() < MO);
      eg = '0; if (ereq && gnt_i) eg[w] = 1'b1;
      er = '0; if (rvalid_i && q.size() > 0) er[q[0]] = 1'b1;
      @(negedge clk);
      tests++;
      if (req_o !== ereq || gnt_o !== eg || rvalid_o !== er) begin
        fails++;
        $display("FAIL rand_handshake_c%0d: req=%b gnt=%b rvalid=%b, required req=%b gnt=%b rvalid=%b",
                 c, req_o, gnt_o, rvalid_o, ereq, eg, er);
      end
      tests++;
      if (spurious !== (rvalid_i && q.size() == 0) || outstanding !== CW'(q.size())) begin
        fails++;
        $display("FAIL rand_status_c%0d: spur=%b outst=%0d, required spur=%b outst=%0d",
                 c, spurious, outstanding, rvalid_i && q.size() == 0, q.size());
      end
      if (ereq) begin
        tests++;
        if (addr_o !== addr_i[w] || we_o !== we_i[w] || be_o !== be_i[w] || wdata_o !== wdata_i[w]) begin
          fails++;
          $display("FAIL rand_mux_c%0d: addr=%h we=%b be=%h wdata=%h, required requester %0d addr=%h",
                   c, addr_o, we_o, be_o, wdata_o, w, addr_i[w]);
        end
      end
      if (rvalid_i) begin
        tests++;
        if (rdata_o[0] !== rdata_i || rdata_o[1] !== rdata_i) begin
          fails++;
          $display("FAIL rand_rdata_c%0d: %h %h, required %h", c, rdata_o[0], rdata_o[1], rdata_i);
        end
      end
      if (rvalid_i && q.size() > 0) void'(q.pop_front());
      if (ereq && gnt_i) begin
        q.push_back(w);
        rr = (w + 1) % N;
        lock = -1;
      end else if (ereq) begin
        lock = w;
      end
      tick();
      if (ereq && gnt_i) req_i[w] = 1'b0;
    end
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_outstanding_limit();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_link_obi_arbiter.md
Name: serial_link_obi_arbiter

Overview:
- Round-robin arbiter that shares the single OBI subordinate port of the serial-link bridge between NumReq OBI managers (e.g. CPU data port, DMA).
- Holds the arbitration decision until grant, as OBI requires.
- Records the winner of every accepted transaction in an in-order ID FIFO and routes each rvalid/rdata back to the requester that issued it.
- Sits in the system clock domain, directly in front of the bridge's OBI-to-AXI-lite conversion.

Parameters:
- NumReq, 2, number of requesting OBI managers (>=2).
- MaxOutstanding, 2, accepted-but-unanswered transactions allowed in flight; matches the bridge request FIFO depth (>=1).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  NumReq  per-requester request.
- addr_i  in  NumReq x AddrWidth  per-requester address.
- we_i  in  NumReq  per-requester write enable.
- be_i  in  NumReq x DataWidth/8  per-requester byte enables.
- wdata_i  in  NumReq x DataWidth  per-requester write data.
- gnt_o  out  NumReq  per-requester grant.
- rvalid_o  out  NumReq  per-requester response valid.
- rdata_o  out  NumReq x DataWidth  per-requester read data; the shared rdata_i is broadcast to all requesters.
- req_o  out  1  request to the bridge.
- addr_o  out  AddrWidth  address to the bridge.
- we_o  out  1  write enable to the bridge.
- be_o  out  DataWidth/8  byte enables to the bridge.
- wdata_o  out  DataWidth  write data to the bridge.
- gnt_i  in  1  grant from the bridge.
- rvalid_i  in  1  response valid from the bridge.
- rdata_i  in  DataWidth  read data from the bridge.
- spurious_rsp_o  out  1  one-cycle pulse when rvalid_i arrives with no transaction outstanding.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current count of outstanding transactions.

Behaviour:
- Single clock domain; asynchronous active-low reset on clk_i/rst_ni.
- Reset values:
  - rr pointer = 0; lock = 0; locked index = 0; count = 0; ID FIFO empty.
  - All outputs 0 in reset and whenever idle.
- Arbitration is combinational, zero latency: gnt_o[w] = gnt_i in the cycle the bridge grants winner w.
- Winner selection:
  - First active req_i at or after the rr pointer, wrapping at NumReq-1 -> 0.
  - Request channels (addr/we/be/wdata) are muxed from the winner.
- Pointer update: on handshake (req_o & gnt_i), pointer <= (w+1) mod NumReq. No update otherwise.
- Lock, two states IDLE and LOCKED:
  - IDLE -> LOCKED when req_o=1 and gnt_i=0; the winner index is registered.
  - In LOCKED, the registered index is the winner regardless of other req_i.
  - LOCKED -> IDLE on gnt_i.
  - A requester dropping req_i while LOCKED is an OBI violation: assertion only, no recovery logic.
- Outstanding limit:
  - req_o is forced to 0 while count == MaxOutstanding.
  - A same-cycle pop does not unmask req_o; this avoids an rvalid_i->req_o combinational path.
  - LOCKED can never coincide with a full FIFO.
- ID FIFO:
  - Push the winner index on handshake; pop on rvalid_i when not empty.
  - rvalid_o[head] = rvalid_i; all other rvalid_o = 0.
  - Simultaneous push and pop leaves count unchanged and keeps order.
- Count arithmetic: +1 on push, -1 on pop; never wraps; count width $clog2(MaxOutstanding+1).
- Empty FIFO with rvalid_i = 1:
  - No rvalid_o asserted.
  - spurious_rsp_o = 1 for that cycle.
  - State unchanged.
- Reset mid-operation: all pending IDs are discarded; responses arriving afterwards are flagged spurious.
- Write transactions also occupy a FIFO entry; the bridge returns rvalid for writes.

Decomposition:
- Package serial_link_arb_pkg: IdxWidth = $clog2(NumReq) helper function and the lock-state enum (IDLE, LOCKED).
- ID FIFO built from the common_cells fifo_v3 (DEPTH = MaxOutstanding, DATA_WIDTH = IdxWidth, FALL_THROUGH = 0).
- Arbitration, lock and muxing stay in this module; rr_arb_tree is not used because the lock semantics differ.

Test Plan:
- Single requester 0 reads 0x1000_0000, gnt_i same cycle, rvalid_i 3 cycles later with rdata 0xDEAD_BEEF -> gnt_o=01, rvalid_o=01, rdata_o[0]=0xDEAD_BEEF, outstanding_o 0->1->0.
- req_i=11 continuously, gnt_i=1, rvalid_i one cycle after each grant -> grants alternate 01,10,01,10; responses route to the matching requester.
- Requester 0 wins, gnt_i held low 4 cycles, requester 1 raises req_i meanwhile -> addr_o stays at requester 0's address; gnt_o[0] on cycle 5; requester 1 granted next.
- MaxOutstanding=2, two grants with no rvalid -> req_o=0 on the third request; rvalid_i pop -> req_o reasserts the following cycle; responses return in issue order.
- rvalid_i pulse with count 0 -> spurious_rsp_o=1 for one cycle, rvalid_o=00, outstanding_o stays 0.
- rst_ni low with 2 outstanding, then released, then rvalid_i -> outstanding_o=0 after reset; spurious_rsp_o pulses; no rvalid_o.
